// File: rtl/sys_reset_sequencer.sv
// Sequenced, synchronised block resets for the APB timer, with a software
// warm-reset handshake that shuts stages down in reverse order and then releases them again.
module sys_reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  ready,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RELEASE  = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_SHUTDOWN = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_ok;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  cnt_last;

  // Assertion is asynchronous; only the release edge is synchronised to sys_clk.
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign sync_ok = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    ack_d   = ack_q;

    case (state_q)
      ST_IDLE: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        ack_d   = 1'b0;
        if (sync_ok) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (cnt_last) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = '0;
          if (idx_q == IDX_LAST) begin
            ready_d = 1'b1;
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (sw_rst_req) begin
          state_d = ST_SHUTDOWN;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = IDX_LAST;
        end
      end

      ST_SHUTDOWN: begin
        // A request dropped here does not abort; HOLD handles the early release.
        if (cnt_last) begin
          rst_n_d[idx_q] = 1'b0;
          cnt_d          = '0;
          if (idx_q == '0) begin
            ack_d   = 1'b1;
            state_d = ST_HOLD;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (!sw_rst_req) begin
          ack_d   = 1'b0;
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        rst_n_d = '0;
        ready_d = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_n_out  = rst_n_q;
  assign ready      = ready_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run, all compared against
// a time-based reference model of the reset sequence.
module tb_sys_reset_sequencer;

  localparam int N    = 4;
  localparam int D    = 16;
  localparam int SYNC = 2;

  localparam int P_WAIT = 0;
  localparam int P_UP   = 1;
  localparam int P_RUN  = 2;
  localparam int P_DOWN = 3;
  localparam int P_HOLD = 4;

  logic         sys_clk = 1'b0;
  logic         sys_reset;
  logic [N-1:0] rst_n_out;
  logic         ready;
  logic         sw_rst_req;
  logic         sw_rst_ack;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase, edges since phase entry, edges since reset release.
  int ph;
  int t;
  int rcnt;
  bit in_rst;

  sys_reset_sequencer #(
    .NUM_STAGES (N),
    .STAGE_DELAY(D),
    .SYNC_STAGES(SYNC),
    .CNT_W      (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .rst_n_out (rst_n_out),
    .ready     (ready),
    .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned low_mask(input int k);
    return (32'd1 << k) - 32'd1;
  endfunction

  function automatic int unsigned exp_rst();
    case (ph)
      P_UP:    return low_mask(t / D);
      P_RUN:   return low_mask(N);
      P_DOWN:  return low_mask(N - t / D);
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    if (in_rst) return;
    case (ph)
      P_WAIT: begin
        rcnt++;
        if (rcnt == SYNC + 1) begin ph = P_UP; t = 0; end
      end
      P_UP: begin
        t++;
        if (t == N * D) ph = P_RUN;
      end
      P_RUN: if (sw_rst_req) begin ph = P_DOWN; t = 0; end
      P_DOWN: begin
        t++;
        if (t == N * D) ph = P_HOLD;
      end
      P_HOLD: if (!sw_rst_req) begin ph = P_UP; t = 0; end
      default: ph = P_WAIT;
    endcase
  endtask

  task automatic compare(input string tag);
    check({tag, ".rst_n"}, 32'(rst_n_out), exp_rst());
    check({tag, ".ready"}, 32'(ready), (ph == P_RUN) ? 1 : 0);
    check({tag, ".ack"}, 32'(sw_rst_ack), (ph == P_HOLD) ? 1 : 0);
  endtask

  // One clock: model follows the posedge, outputs are compared at the negedge.
  task automatic step(input string tag);
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    compare(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Asserts reset mid-cycle, checks outputs cleared with no edge, then releases at a negedge.
  task automatic pulse_reset(input int hold_cycles);
    #1 sys_reset = 1'b0;
    in_rst = 1'b1;
    ph     = P_WAIT;
    rcnt   = 0;
    t      = 0;
    #1 compare("async");
    run("in_reset", hold_cycles);
    sys_reset = 1'b1;
    in_rst    = 1'b0;
  endtask

  initial begin
    sys_reset  = 1'b0;
    sw_rst_req = 1'b0;
    in_rst     = 1'b1;
    ph         = P_WAIT;
    t          = 0;
    rcnt       = 0;

    // 1: power-on, full forward release
    run("por_reset", 3);
    @(negedge sys_clk);
    sys_reset = 1'b1;
    in_rst    = 1'b0;
    run("por", SYNC + 1 + N * D + 4);

    // 2: abort while two stages are released
    pulse_reset(2);
    run("abort_pre", SYNC + 1 + 2 * D + 3);
    check("abort_at_0011", 32'(rst_n_out), 32'h3);
    pulse_reset(1);
    run("abort_restart", SYNC + 1 + N * D + 2);

    // 3: warm reset with a held request
    sw_rst_req = 1'b1;
    run("warm_down", N * D + 5);
    sw_rst_req = 1'b0;
    run("warm_up", N * D + 4);

    // 5: single-cycle request pulse in RUN
    sw_rst_req = 1'b1;
    step("pulse");
    sw_rst_req = 1'b0;
    run("pulse_seq", 2 * N * D + 6);

    // 4: request held from reset through power-on release
    sw_rst_req = 1'b1;
    pulse_reset(2);
    run("early", SYNC + 1 + 2 * N * D + 4);

    // 6: async reset while in HOLD with the request still high
    check("hold_ack_before", 32'(sw_rst_ack), 32'd1);
    pulse_reset(2);
    run("post_hold", SYNC + 1 + N * D + 3);
    sw_rst_req = 1'b0;
    run("post_hold_rel", 4);

    // Randomized: request toggling plus occasional async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 24) == 0) begin
        sw_rst_req = ~sw_rst_req;
      end
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
